sram_test_master: RTL and testbench
===================================

SRAM_TEST_MASTER -- requirements
Module: sram_test_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data bus width, always >= ADDR_WIDTH.
REQ-003 SHALL have parameter PATTERN_SEED, default 16'hA5A5 truncated or zero-extended to DATA_WIDTH, the XOR seed for test data.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum wait cycles per handshake phase.
REQ-005 SHALL have one clock and an asynchronous active-high reset.
REQ-006 proc_clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start_i  in  1  one-cycle start pulse.
REQ-009 start_addr_i  in  ADDR_WIDTH  first test address.
REQ-010 end_addr_i  in  ADDR_WIDTH  last test address.
REQ-011 req_o  out  1  request to the controller.
REQ-012 wr_en_o  out  1  1=write, 0=read.
REQ-013 addr_o  out  ADDR_WIDTH  access address.
REQ-014 wdata_o  out  DATA_WIDTH  write data.
REQ-015 ack_i  in  1  controller acknowledge, level.
REQ-016 rdata_i  in  DATA_WIDTH  controller read data.
REQ-017 busy_o  out  1  test in progress.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 pass_o  out  1  last test passed; held until next start.
REQ-020 timeout_o  out  1  last test aborted on timeout; held until next start.
REQ-021 err_count_o  out  16  mismatch count, saturating.
REQ-022 fail_addr_o  out  ADDR_WIDTH  address of the first mismatch.
REQ-023 fail_data_o  out  DATA_WIDTH  read data of the first mismatch.

Function
REQ-024 Pattern: SHALL compute pattern(a) = PATTERN_SEED XOR zero-extend(a).
REQ-025 States SHALL be IDLE, W_REQ, W_REL, R_REQ, R_CAP, R_REL and DONE; all outputs SHALL be registered.
REQ-026 IDLE: on start_i, SHALL latch the start/end addresses, clear err_count/fail_*/pass/timeout, set addr to start, and go to W_REQ.
REQ-027 W_REQ: SHALL drive req_o=1, wr_en_o=1, addr_o=addr, wdata_o=pattern(addr), and hold them stable until the cycle after ack_i=1 is sampled, then go to W_REL.
REQ-028 W_REL: SHALL hold req_o=0 and wait for ack_i=0; then if addr==end, set addr=start and go to R_REQ; else addr+1, go to W_REQ.
REQ-029 R_REQ: SHALL drive req_o=1 and wr_en_o=0; on ack_i=1, go to R_CAP with req_o=0.
REQ-030 R_CAP: SHALL sample rdata_i exactly one cycle after ack_i was seen; on mismatch, SHALL increment err_count (saturating at 16'hFFFF) and, on the first mismatch only, capture fail_addr/fail_data; then go to R_REL.
REQ-031 R_REL: SHALL wait for ack_i=0; if addr==end, go to DONE; else addr+1, go to R_REQ.
REQ-032 Handshake: SHALL be four-phase; a new request SHALL never be raised while ack_i=1.
REQ-033 Address SHALL increment modulo 2^ADDR_WIDTH; end < start SHALL wrap through the top address; start == end SHALL test exactly one location.
REQ-034 Timeout counter SHALL reset on each state entry; if it reaches TIMEOUT_CYCLES in W_REQ/W_REL/R_REQ/R_REL, SHALL drop req_o, set timeout_o=1, pass_o=0, and go to DONE.
REQ-035 DONE: SHALL pulse done_o for one cycle, set pass_o=(err_count==0 && !timeout), and return to IDLE.
REQ-036 busy_o SHALL be 1 in every state except IDLE; start_i while busy SHALL be ignored.
REQ-037 wr_en_o/addr_o/wdata_o SHALL change only while req_o=0 or on request entry.

Reset
REQ-038 rst=1 SHALL immediately force IDLE and set every output and counter to 0, including req_o=0.
REQ-039 Reset mid-operation SHALL abandon the test with no done_o pulse; the next start SHALL restart cleanly.

Verification
REQ-040 With the controller and SRAM model, start 0x10..0x12 -> writes 0xA5B5, 0xA5B4, 0xA5B7, then three matching reads; done_o pulses, pass_o=1, err_count_o=0.
REQ-041 Bench responder corrupts the read at 0x11 to 0x0000 -> err_count_o=1, fail_addr_o=0x11, fail_data_o=0x0000, pass_o=0.
REQ-042 ack_i held 0 -> after 255 cycles in W_REQ: req_o=0, timeout_o=1, pass_o=0, done_o pulses once.
REQ-043 Range 0xFE..0x01 -> accesses 0xFE, 0xFF, 0x00, 0x01 in both phases; pass_o=1.
REQ-044 rst asserted during R_REQ -> req_o=0 asynchronously, busy_o=0, no done_o; a second start of 0x20..0x20 passes.
REQ-045 start_i pulsed while busy with different addresses -> ignored; the original range completes unchanged.

Source files
------------

// File: rtl/sram_test_master_if.sv
// sram_test_master_if: request/acknowledge bus between the SRAM test master and an SRAM controller
// master drives req_o/wr_en_o/addr_o/wdata_o; slave returns level ack_i and rdata_i
interface sram_test_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  ack_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  modport master (output req_o, wr_en_o, addr_o, wdata_o, input ack_i, rdata_i);
  modport slave (input req_o, wr_en_o, addr_o, wdata_o, output ack_i, rdata_i);
endinterface

// File: rtl/sram_test_master.sv
// sram_test_master: writes seed^address over an address range, reads it back and reports mismatches
// proc_clk/rst: clock and async active-high reset; start_i/start_addr_i/end_addr_i: test launch
// bus: four-phase request/acknowledge master port to the SRAM controller
// busy_o/done_o/pass_o/timeout_o/err_count_o/fail_addr_o/fail_data_o: test status and first-failure capture
module sram_test_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PATTERN_SEED = DATA_WIDTH'(16'hA5A5),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  proc_clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  sram_test_master_if.master    bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, W_REQ, W_REL, R_REQ, R_CAP, R_REL, DONE} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] start_q, end_q, addr, addr_nx;
  logic [DATA_WIDTH-1:0] wdata;
  logic [TW-1:0]         tcnt;
  logic                  req, wr_en, tmo;
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return PATTERN_SEED ^ DATA_WIDTH'(a);
  endfunction
  assign addr_nx     = addr + 1'b1;
  // tcnt reaching TLIM means this is the TIMEOUT_CYCLES-th cycle spent waiting in the state
  assign tmo         = tcnt == TLIM && state inside {W_REQ, W_REL, R_REQ, R_REL};
  assign bus.req_o   = req;
  assign bus.wr_en_o = wr_en;
  assign bus.addr_o  = addr;
  assign bus.wdata_o = wdata;
  always_ff @(posedge proc_clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      addr        <= '0;
      wdata       <= '0;
      tcnt        <= '0;
      req         <= 1'b0;
      wr_en       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_count_o <= '0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else begin
      done_o <= 1'b0;
      tcnt   <= tcnt + 1'b1;
      if (tmo) begin
        req       <= 1'b0;
        timeout_o <= 1'b1;
        pass_o    <= 1'b0;
        tcnt      <= '0;
        state     <= DONE;
      end else
        case (state)
          IDLE: if (start_i) begin
            start_q     <= start_addr_i;
            end_q       <= end_addr_i;
            addr        <= start_addr_i;
            wdata       <= pattern(start_addr_i);
            req         <= 1'b1;
            wr_en       <= 1'b1;
            busy_o      <= 1'b1;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            tcnt        <= '0;
            state       <= W_REQ;
          end
          W_REQ: if (bus.ack_i) begin
            req   <= 1'b0;
            tcnt  <= '0;
            state <= W_REL;
          end
          // the next request is raised only on the edge that sees ack low
          W_REL: if (!bus.ack_i) begin
            tcnt <= '0;
            req  <= 1'b1;
            if (addr == end_q) begin
              addr  <= start_q;
              wr_en <= 1'b0;
              state <= R_REQ;
            end else begin
              addr  <= addr_nx;
              wdata <= pattern(addr_nx);
              state <= W_REQ;
            end
          end
          R_REQ: if (bus.ack_i) begin
            req   <= 1'b0;
            tcnt  <= '0;
            state <= R_CAP;
          end
          R_CAP: begin
            if (bus.rdata_i != pattern(addr)) begin
              err_count_o <= err_count_o + {15'd0, err_count_o != 16'hFFFF};
              if (err_count_o == '0) begin
                fail_addr_o <= addr;
                fail_data_o <= bus.rdata_i;
              end
            end
            tcnt  <= '0;
            state <= R_REL;
          end
          R_REL: if (!bus.ack_i) begin
            tcnt <= '0;
            if (addr == end_q) state <= DONE;
            else begin
              addr  <= addr_nx;
              req   <= 1'b1;
              state <= R_REQ;
            end
          end
          DONE: begin
            done_o <= 1'b1;
            pass_o <= err_count_o == '0 && !timeout_o;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_test_master.sv
// tb_sram_test_master: directed checks of the SRAM test master against a behavioural four-phase SRAM responder
module tb_sram_test_master;
  logic        proc_clk, rst, start_i;
  logic [7:0]  start_addr_i, end_addr_i, fail_addr_o;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_count_o, fail_data_o;
  int          total, bad, done_cnt;
  logic        mute;
  logic [7:0]  clo, chi;
  logic [15:0] mem [256];
  logic [7:0]  wr_a[$], rd_a[$];
  logic [15:0] wr_d[$];

  sram_test_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus();

  sram_test_master #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .proc_clk(proc_clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i),
    .end_addr_i(end_addr_i), .bus(bus), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .err_count_o(err_count_o), .fail_addr_o(fail_addr_o),
    .fail_data_o(fail_data_o)
  );

  initial begin
    proc_clk = 0;
    forever #5 proc_clk = ~proc_clk;
  end

  initial begin
    bus.ack_i = 0;
    bus.rdata_i = 0;
    forever begin
      @(posedge proc_clk);
      #1;
      if (bus.req_o && !bus.ack_i && !mute) begin
        bus.ack_i = 1;
        if (bus.wr_en_o) begin
          mem[bus.addr_o] = bus.wdata_o;
          wr_a.push_back(bus.addr_o);
          wr_d.push_back(bus.wdata_o);
        end else begin
          rd_a.push_back(bus.addr_o);
          bus.rdata_i = (bus.addr_o >= clo && bus.addr_o <= chi) ? 16'h0000 : mem[bus.addr_o];
        end
      end else if (!bus.req_o && bus.ack_i) bus.ack_i = 0;
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge proc_clk);
      if (done_o) done_cnt++;
    end
  end

  task automatic pulse_start(input logic [7:0] sa, input logic [7:0] ea);
    @(negedge proc_clk);
    start_i = 1;
    start_addr_i = sa;
    end_addr_i = ea;
    @(negedge proc_clk);
    start_i = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge proc_clk);
      if (done_o) ok = 1;
    end
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge proc_clk);
    total++;
    if ({bus.req_o, bus.wr_en_o, bus.addr_o, bus.wdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_bus got=%b/%b/%h/%h exp=0/0/00/0000", bus.req_o, bus.wr_en_o, bus.addr_o, bus.wdata_o);
    end
    total++;
    if ({busy_o, done_o, pass_o, timeout_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b%b%b%b exp=0000", busy_o, done_o, pass_o, timeout_o);
    end
    total++;
    if ({err_count_o, fail_addr_o, fail_data_o} !== '0) begin
      bad++;
      $display("FAIL reset_stats got=%h/%h/%h exp=0000/00/0000", err_count_o, fail_addr_o, fail_data_o);
    end
    rst = 0;
    @(negedge proc_clk);
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    logic [7:0]  xa[3];
    logic [15:0] xd[3];
    xa = '{8'h10, 8'h11, 8'h12};
    xd = '{16'hA5B5, 16'hA5B4, 16'hA5B7};
    clear_log();
    d0 = done_cnt;
    pulse_start(8'h10, 8'h12);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done got=0 exp=1"); end
    total++;
    if ({pass_o, timeout_o, busy_o, err_count_o} !== {3'b100, 16'h0}) begin
      bad++;
      $display("FAIL basic_status pass/tmo/busy/err got=%b%b%b/%h exp=100/0000", pass_o, timeout_o, busy_o, err_count_o);
    end
    total++;
    if (wr_a.size() != 3 || rd_a.size() != 3) begin
      bad++;
      $display("FAIL basic_len got wr=%0d rd=%0d exp=3", wr_a.size(), rd_a.size());
    end else
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_a[i] !== xa[i] || wr_d[i] !== xd[i] || rd_a[i] !== xa[i]) begin
          bad++;
          $display("FAIL basic_access[%0d] got wr=%h:%h rd=%h exp wr=%h:%h rd=%h", i, wr_a[i], wr_d[i], rd_a[i], xa[i], xd[i], xa[i]);
        end
      end
    repeat (3) @(negedge proc_clk);
    total++;
    if (done_cnt - d0 != 1 || done_o !== 1'b0 || pass_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_after got done_cnt=%0d done=%b pass=%b exp=1/0/1", done_cnt - d0, done_o, pass_o);
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    clo = 8'h11;
    chi = 8'h11;
    pulse_start(8'h10, 8'h12);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL corrupt_done got=0 exp=1"); end
    total++;
    if ({err_count_o, fail_addr_o, fail_data_o, pass_o} !== {16'd1, 8'h11, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL corrupt_status got err=%h addr=%h data=%h pass=%b exp 0001/11/0000/0", err_count_o, fail_addr_o, fail_data_o, pass_o);
    end
    clo = 8'h11;
    chi = 8'h12;
    pulse_start(8'h10, 8'h12);
    wait_done(ok);
    total++;
    if ({ok, err_count_o, fail_addr_o, fail_data_o, pass_o} !== {1'b1, 16'd2, 8'h11, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL first_only got done=%b err=%h addr=%h data=%h pass=%b exp 1/0002/11/0000/0", ok, err_count_o, fail_addr_o, fail_data_o, pass_o);
    end
    clo = 8'h01;
    chi = 8'h00;
  endtask

  task automatic test_timeout();
    bit ok;
    int n, d0;
    mute = 1;
    d0 = done_cnt;
    pulse_start(8'h30, 8'h31);
    n = 0;
    while (bus.req_o && n < 400) begin
      n++;
      @(negedge proc_clk);
    end
    total++;
    if (n != 255) begin bad++; $display("FAIL timeout_cycles got=%0d exp=255", n); end
    wait_done(ok);
    total++;
    if ({ok, bus.req_o, timeout_o, pass_o, busy_o} !== 5'b10100) begin
      bad++;
      $display("FAIL timeout_status got done/req/tmo/pass/busy=%b%b%b%b%b exp=10100", ok, bus.req_o, timeout_o, pass_o, busy_o);
    end
    repeat (5) @(negedge proc_clk);
    total++;
    if (done_cnt - d0 != 1 || timeout_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_once got done_cnt=%0d tmo=%b exp=1/1", done_cnt - d0, timeout_o);
    end
    mute = 0;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0]  xa[4];
    logic [15:0] xd[4];
    xa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    xd = '{16'hA55B, 16'hA55A, 16'hA5A5, 16'hA5A4};
    clear_log();
    pulse_start(8'hFE, 8'h01);
    wait_done(ok);
    total++;
    if ({ok, pass_o, timeout_o, err_count_o} !== {3'b110, 16'h0}) begin
      bad++;
      $display("FAIL wrap_status got done/pass/tmo/err=%b%b%b/%h exp=110/0000", ok, pass_o, timeout_o, err_count_o);
    end
    total++;
    if (wr_a.size() != 4 || rd_a.size() != 4) begin
      bad++;
      $display("FAIL wrap_len got wr=%0d rd=%0d exp=4", wr_a.size(), rd_a.size());
    end else
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_a[i] !== xa[i] || wr_d[i] !== xd[i] || rd_a[i] !== xa[i]) begin
          bad++;
          $display("FAIL wrap_access[%0d] got wr=%h:%h rd=%h exp wr=%h:%h rd=%h", i, wr_a[i], wr_d[i], rd_a[i], xa[i], xd[i], xa[i]);
        end
      end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n, d0;
    pulse_start(8'h40, 8'h43);
    n = 0;
    while (!(bus.req_o && !bus.wr_en_o) && n < 200) begin
      n++;
      @(negedge proc_clk);
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL midrst_reach_rreq got=timeout exp=R_REQ"); end
    d0 = done_cnt;
    #1 rst = 1;
    #1;
    total++;
    if ({bus.req_o, busy_o, err_count_o} !== '0) begin
      bad++;
      $display("FAIL midrst_async got req/busy/err=%b%b/%h exp=00/0000", bus.req_o, busy_o, err_count_o);
    end
    @(negedge proc_clk);
    rst = 0;
    repeat (5) @(negedge proc_clk);
    total++;
    if (done_cnt != d0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_done got done_cnt=%0d busy=%b exp=0/0", done_cnt - d0, busy_o);
    end
    clear_log();
    pulse_start(8'h20, 8'h20);
    wait_done(ok);
    total++;
    if ({ok, pass_o, wr_a.size() == 1, rd_a.size() == 1} !== 4'b1111) begin
      bad++;
      $display("FAIL midrst_restart got done=%b pass=%b wr=%0d rd=%0d exp=1/1/1/1", ok, pass_o, wr_a.size(), rd_a.size());
    end else begin
      total++;
      if (wr_a[0] !== 8'h20 || wr_d[0] !== 16'hA585 || rd_a[0] !== 8'h20) begin
        bad++;
        $display("FAIL midrst_single got wr=%h:%h rd=%h exp wr=20:a585 rd=20", wr_a[0], wr_d[0], rd_a[0]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [7:0]  xa[3];
    logic [15:0] xd[3];
    xa = '{8'h50, 8'h51, 8'h52};
    xd = '{16'hA5F5, 16'hA5F4, 16'hA5F7};
    clear_log();
    pulse_start(8'h50, 8'h52);
    repeat (3) @(negedge proc_clk);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_flag got=%b exp=1", busy_o); end
    pulse_start(8'h60, 8'h61);
    wait_done(ok);
    total++;
    if ({ok, pass_o} !== 2'b11 || wr_a.size() != 3 || rd_a.size() != 3) begin
      bad++;
      $display("FAIL busy_ignore got done=%b pass=%b wr=%0d rd=%0d exp=1/1/3/3", ok, pass_o, wr_a.size(), rd_a.size());
    end else
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_a[i] !== xa[i] || wr_d[i] !== xd[i] || rd_a[i] !== xa[i]) begin
          bad++;
          $display("FAIL busy_access[%0d] got wr=%h:%h rd=%h exp wr=%h:%h rd=%h", i, wr_a[i], wr_d[i], rd_a[i], xa[i], xd[i], xa[i]);
        end
      end
    repeat (4) @(negedge proc_clk);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_restart got busy=%b exp=0", busy_o); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mute = 0;
    clo = 8'h01;
    chi = 8'h00;
    start_i = 0;
    start_addr_i = 0;
    end_addr_i = 0;
    rst = 1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_corrupt();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
